// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit ALU between the execute stage (requester 0)
// and the address/branch unit (requester 1). A valid/ready handshake is used
// on each request port. The granted operation is evaluated combinationally
// and its result is captured in a one-entry response buffer, tagged with the
// requester id.
// Optional feature macro: ALU_ARB_OPCHK_EN adds resp_illegal, which flags a
// control code outside the seven supported operations.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int RR_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_ctrl,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_ctrl,
  output logic             req1_ready,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  input  logic             resp_ready
`ifdef ALU_ARB_OPCHK_EN
  ,
  output logic             resp_illegal
`endif
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  localparam logic RR = (RR_EN != 0);

  state_e           state_q;
  logic             last_grant_q;
  logic             resp_valid_q;
  logic             resp_id_q;
  logic [WIDTH-1:0] resp_result_q;
  logic             resp_zero_q;
`ifdef ALU_ARB_OPCHK_EN
  logic             resp_illegal_q;
  logic             illegal_d;
`endif

  logic             buf_free;
  logic             grant;
  logic             xfer;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_ctrl;
  logic [WIDTH-1:0] result_d;
  logic             zero_d;

  // In HOLD the buffer frees up in the same cycle the consumer takes it.
  assign buf_free = (state_q == IDLE) || resp_ready;

  // Arbitration: ready depends only on valids, buffer state and the pointer.
  // A tie under round-robin goes to the requester not granted last time.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && buf_free) begin
      if (req0_valid && req1_valid) begin
        if (RR && !last_grant_q) req1_ready = 1'b1;
        else                     req0_ready = 1'b1;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign grant = req1_ready;
  assign xfer  = req0_ready || req1_ready;

  // Operand mux: requester 0 is selected whenever nobody is granted.
  always_comb begin
    op_a    = grant ? req1_a    : req0_a;
    op_b    = grant ? req1_b    : req0_b;
    op_ctrl = grant ? req1_ctrl : req0_ctrl;
  end

  // Shared ALU: unsupported codes produce a zero result.
  always_comb begin
    result_d = '0;
`ifdef ALU_ARB_OPCHK_EN
    illegal_d = 1'b0;
`endif
    case (op_ctrl)
      4'b0000: result_d = op_a & op_b;
      4'b0001: result_d = op_a | op_b;
      4'b0010: result_d = op_a + op_b;
      4'b0110: result_d = op_a - op_b;
      4'b0111: result_d = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      4'b1100: result_d = ~(op_a | op_b);
      4'b1101: result_d = op_a ^ op_b;
      default: begin
        result_d = '0;
`ifdef ALU_ARB_OPCHK_EN
        illegal_d = 1'b1;
`endif
      end
    endcase
  end

  assign zero_d = (result_d == '0);

  // Buffer FSM: load on every accepted request, drain to IDLE when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
      resp_illegal_q <= 1'b0;
`endif
    end else begin
      if (xfer) begin
        resp_valid_q  <= 1'b1;
        resp_id_q     <= grant;
        resp_result_q <= result_d;
        resp_zero_q   <= zero_d;
        last_grant_q  <= grant;
`ifdef ALU_ARB_OPCHK_EN
        resp_illegal_q <= illegal_d;
`endif
      end
      case (state_q)
        IDLE: begin
          if (xfer) state_q <= HOLD;
        end
        HOLD: begin
          if (!xfer && resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_zero   = resp_zero_q;
`ifdef ALU_ARB_OPCHK_EN
  assign resp_illegal = resp_illegal_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a round-robin instance and a fixed-priority
// instance share the same stimulus. Directed scenarios are followed by a
// randomized run against a transaction-level reference model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, resp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;

  logic        rr_req0_ready, rr_req1_ready, rr_resp_valid, rr_resp_id, rr_resp_zero;
  logic [31:0] rr_resp_result;
  logic        fp_req0_ready, fp_req1_ready, fp_resp_valid, fp_resp_id, fp_resp_zero;
  logic [31:0] fp_resp_result;
`ifdef ALU_ARB_OPCHK_EN
  logic        rr_resp_illegal, fp_resp_illegal;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .RR_EN(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req0_ready(rr_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .req1_ready(rr_req1_ready),
    .resp_valid(rr_resp_valid), .resp_id(rr_resp_id), .resp_result(rr_resp_result),
    .resp_zero(rr_resp_zero), .resp_ready(resp_ready)
`ifdef ALU_ARB_OPCHK_EN
    , .resp_illegal(rr_resp_illegal)
`endif
  );

  alu_arbiter #(.WIDTH(32), .RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req0_ready(fp_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .req1_ready(fp_req1_ready),
    .resp_valid(fp_resp_valid), .resp_id(fp_resp_id), .resp_result(fp_resp_result),
    .resp_zero(fp_resp_zero), .resp_ready(resp_ready)
`ifdef ALU_ARB_OPCHK_EN
    , .resp_illegal(fp_resp_illegal)
`endif
  );

  // Reference ALU straight from the operation table: {zero, result}.
  function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    logic [31:0] r;
    if      (c == 4'h0) r = a & b;
    else if (c == 4'h1) r = a | b;
    else if (c == 4'h2) r = a + b;
    else if (c == 4'h6) r = a - b;
    else if (c == 4'h7) r = (a < b) ? 32'd1 : 32'd0;
    else if (c == 4'hC) r = ~(a | b);
    else if (c == 4'hD) r = a ^ b;
    else                r = 32'd0;
    return {(r == 32'd0), r};
  endfunction

  function automatic bit is_legal(input logic [3:0] c);
    return (c == 4'h0) || (c == 4'h1) || (c == 4'h2) || (c == 4'h6) ||
           (c == 4'h7) || (c == 4'hC) || (c == 4'hD);
  endfunction

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
    resp_ready = 1'b0;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    next_edge();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    resp_ready = 1'b1;
    next_edge();
    total_cnt++;
    if ({rr_resp_valid, rr_resp_id, rr_resp_zero, rr_resp_result} !== 35'd0)
      $display("FAIL reset_resp: got v=%0b id=%0b z=%0b r=%0h want all 0",
               rr_resp_valid, rr_resp_id, rr_resp_zero, rr_resp_result);
    else pass_cnt++;
    total_cnt++;
    if ({rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready} !== 4'b0000)
      $display("FAIL reset_ready: got %b want 0000",
               {rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready});
    else pass_cnt++;
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 4'b0010;
    resp_ready = 1'b1;
    #1;
    total_cnt++;
    if ({rr_req0_ready, rr_req1_ready} !== 2'b10)
      $display("FAIL single_ready: got %b want 10", {rr_req0_ready, rr_req1_ready});
    else pass_cnt++;
    next_edge();
    req0_valid = 1'b0;
    total_cnt++;
    if ({rr_resp_valid, rr_resp_id, rr_resp_result, rr_resp_zero} !== {1'b1, 1'b0, 32'd8, 1'b0})
      $display("FAIL single_resp: got v=%0b id=%0b r=%0h z=%0b want v=1 id=0 r=8 z=0",
               rr_resp_valid, rr_resp_id, rr_resp_result, rr_resp_zero);
    else pass_cnt++;
    next_edge();
    total_cnt++;
    if (rr_resp_valid !== 1'b0)
      $display("FAIL single_drain: got v=%0b want 0", rr_resp_valid);
    else pass_cnt++;
  endtask

  task automatic test_rr_conflict();
    apply_reset();
    req0_valid = 1'b1; req0_a = 32'd7;    req0_b = 32'd7;    req0_ctrl = 4'b0110;
    req1_valid = 1'b1; req1_a = 32'hFF;   req1_b = 32'h0F;   req1_ctrl = 4'b1101;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit g;
      g = (i % 2) == 1;
      #1;
      total_cnt++;
      if ({rr_req0_ready, rr_req1_ready} !== (g ? 2'b01 : 2'b10))
        $display("FAIL rr_grant%0d: got %b want %b", i, {rr_req0_ready, rr_req1_ready},
                 (g ? 2'b01 : 2'b10));
      else pass_cnt++;
      total_cnt++;
      if ({fp_req0_ready, fp_req1_ready} !== 2'b10)
        $display("FAIL fp_grant%0d: got %b want 10", i, {fp_req0_ready, fp_req1_ready});
      else pass_cnt++;
      next_edge();
      total_cnt++;
      if ({rr_resp_valid, rr_resp_id, rr_resp_result, rr_resp_zero} !==
          {1'b1, g, (g ? 32'hF0 : 32'h0), !g})
        $display("FAIL rr_resp%0d: got v=%0b id=%0b r=%0h z=%0b want id=%0b",
                 i, rr_resp_valid, rr_resp_id, rr_resp_result, rr_resp_zero, g);
      else pass_cnt++;
      total_cnt++;
      if ({fp_resp_valid, fp_resp_id, fp_resp_result, fp_resp_zero} !== {1'b1, 1'b0, 32'h0, 1'b1})
        $display("FAIL fp_resp%0d: got v=%0b id=%0b r=%0h z=%0b want v=1 id=0 r=0 z=1",
                 i, fp_resp_valid, fp_resp_id, fp_resp_result, fp_resp_zero);
      else pass_cnt++;
    end
  endtask

  task automatic test_fixed_priority();
    req0_valid = 1'b0;
    #1;
    total_cnt++;
    if ({fp_req0_ready, fp_req1_ready} !== 2'b01)
      $display("FAIL fp_req1_only: got %b want 01", {fp_req0_ready, fp_req1_ready});
    else pass_cnt++;
    next_edge();
    total_cnt++;
    if ({fp_resp_valid, fp_resp_id, fp_resp_result, fp_resp_zero} !== {1'b1, 1'b1, 32'hF0, 1'b0})
      $display("FAIL fp_req1_resp: got v=%0b id=%0b r=%0h z=%0b want v=1 id=1 r=f0 z=0",
               fp_resp_valid, fp_resp_id, fp_resp_result, fp_resp_zero);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_backpressure();
    apply_reset();
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_ctrl = 4'b0010;
    resp_ready = 1'b0;
    #1;
    total_cnt++;
    if ({rr_req0_ready, rr_req1_ready} !== 2'b10)
      $display("FAIL bp_accept: got %b want 10", {rr_req0_ready, rr_req1_ready});
    else pass_cnt++;
    next_edge();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h0F0; req1_b = 32'h00F; req1_ctrl = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++;
      if ({rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready} !== 4'b0000)
        $display("FAIL bp_ready%0d: got %b want 0000", i,
                 {rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready});
      else pass_cnt++;
      total_cnt++;
      if ({rr_resp_valid, rr_resp_id, rr_resp_result, rr_resp_zero} !== {1'b1, 1'b0, 32'd30, 1'b0})
        $display("FAIL bp_hold%0d: got v=%0b id=%0b r=%0h z=%0b want v=1 id=0 r=1e z=0",
                 i, rr_resp_valid, rr_resp_id, rr_resp_result, rr_resp_zero);
      else pass_cnt++;
      next_edge();
    end
    resp_ready = 1'b1;
    #1;
    total_cnt++;
    if ({rr_req0_ready, rr_req1_ready} !== 2'b01)
      $display("FAIL bp_drain_accept: got %b want 01", {rr_req0_ready, rr_req1_ready});
    else pass_cnt++;
    next_edge();
    total_cnt++;
    if ({rr_resp_valid, rr_resp_id, rr_resp_result, rr_resp_zero} !== {1'b1, 1'b1, 32'hFF, 1'b0})
      $display("FAIL bp_reload: got v=%0b id=%0b r=%0h z=%0b want v=1 id=1 r=ff z=0",
               rr_resp_valid, rr_resp_id, rr_resp_result, rr_resp_zero);
    else pass_cnt++;
    req1_valid = 1'b0;
    resp_ready = 1'b0;
    next_edge();
  endtask

  task automatic test_async_reset();
    // Buffer is held at this point; pull reset between clock edges.
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    total_cnt++;
    if ({rr_resp_valid, rr_resp_result} !== 33'd0)
      $display("FAIL async_clear: got v=%0b r=%0h want v=0 r=0", rr_resp_valid, rr_resp_result);
    else pass_cnt++;
    total_cnt++;
    if ({rr_req0_ready, rr_req1_ready} !== 2'b00)
      $display("FAIL async_ready: got %b want 00", {rr_req0_ready, rr_req1_ready});
    else pass_cnt++;
    #2;
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if ({rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready} !== 4'b1010)
      $display("FAIL async_first_tie: got %b want 1010",
               {rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready});
    else pass_cnt++;
    idle_inputs();
    next_edge();
  endtask

  task automatic test_illegal();
    apply_reset();
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 4'b1111;
    resp_ready = 1'b1;
    next_edge();
    total_cnt++;
    if ({rr_resp_valid, rr_resp_result, rr_resp_zero} !== {1'b1, 32'd0, 1'b1})
      $display("FAIL illegal_resp: got v=%0b r=%0h z=%0b want v=1 r=0 z=1",
               rr_resp_valid, rr_resp_result, rr_resp_zero);
    else pass_cnt++;
`ifdef ALU_ARB_OPCHK_EN
    total_cnt++;
    if (rr_resp_illegal !== 1'b1)
      $display("FAIL illegal_flag: got %0b want 1", rr_resp_illegal);
    else pass_cnt++;
`endif
    req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = 4'b0111;
    next_edge();
    total_cnt++;
    if ({rr_resp_valid, rr_resp_result, rr_resp_zero} !== {1'b1, 32'd1, 1'b0})
      $display("FAIL slt_resp: got v=%0b r=%0h z=%0b want v=1 r=1 z=0",
               rr_resp_valid, rr_resp_result, rr_resp_zero);
    else pass_cnt++;
`ifdef ALU_ARB_OPCHK_EN
    total_cnt++;
    if (rr_resp_illegal !== 1'b0)
      $display("FAIL legal_flag: got %0b want 0", rr_resp_illegal);
    else pass_cnt++;
`endif
    idle_inputs();
    next_edge();
  endtask

  task automatic test_random();
    // Per-instance model: index 0 is round-robin, 1 is fixed priority.
    bit          m_v[2], m_id[2], m_z[2], m_ill[2], m_last[2];
    logic [31:0] m_r[2];
    int          g[2];
    logic [3:0]  legal[7];
    legal = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'hD};
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 0; m_id[k] = 0; m_z[k] = 0; m_ill[k] = 0; m_last[k] = 1; m_r[k] = '0;
    end
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_a = $urandom;
      req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
      req1_a = $urandom;
      req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
      req0_ctrl = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                              : legal[$urandom_range(0, 6)];
      req1_ctrl = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                              : legal[$urandom_range(0, 6)];
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        logic [1:0] exp_rdy, obs_rdy;
        g[k] = -1;
        if (!m_v[k] || resp_ready) begin
          if (req0_valid && req1_valid) g[k] = (k == 0 && !m_last[k]) ? 1 : 0;
          else if (req0_valid)          g[k] = 0;
          else if (req1_valid)          g[k] = 1;
        end
        exp_rdy = (g[k] == 0) ? 2'b10 : (g[k] == 1) ? 2'b01 : 2'b00;
        obs_rdy = (k == 0) ? {rr_req0_ready, rr_req1_ready} : {fp_req0_ready, fp_req1_ready};
        total_cnt++;
        if (obs_rdy !== exp_rdy)
          $display("FAIL rand_ready inst%0d cyc%0d: got %b want %b", k, i, obs_rdy, exp_rdy);
        else pass_cnt++;
      end
      next_edge();
      for (int k = 0; k < 2; k++) begin
        logic [34:0] obs, exp_v;
        if (g[k] >= 0) begin
          logic [32:0] zr;
          logic [3:0]  c;
          c  = (g[k] == 1) ? req1_ctrl : req0_ctrl;
          zr = (g[k] == 1) ? alu_ref(req1_a, req1_b, c) : alu_ref(req0_a, req0_b, c);
          m_v[k] = 1; m_id[k] = (g[k] == 1); m_r[k] = zr[31:0]; m_z[k] = zr[32];
          m_ill[k] = !is_legal(c); m_last[k] = (g[k] == 1);
        end else if (m_v[k] && resp_ready) begin
          m_v[k] = 0;
        end
        obs = (k == 0) ? {rr_resp_valid, rr_resp_id, rr_resp_result, rr_resp_zero}
                       : {fp_resp_valid, fp_resp_id, fp_resp_result, fp_resp_zero};
        exp_v = {m_v[k], m_id[k], m_r[k], m_z[k]};
        if (!m_v[k]) begin
          obs   = {obs[34], 34'd0};
          exp_v = 35'd0;
        end
        total_cnt++;
        if (obs !== exp_v)
          $display("FAIL rand_resp inst%0d cyc%0d: got %h want %h", k, i, obs, exp_v);
        else pass_cnt++;
`ifdef ALU_ARB_OPCHK_EN
        if (m_v[k]) begin
          total_cnt++;
          if (((k == 0) ? rr_resp_illegal : fp_resp_illegal) !== m_ill[k])
            $display("FAIL rand_illegal inst%0d cyc%0d: got %0b want %0b", k, i,
                     ((k == 0) ? rr_resp_illegal : fp_resp_illegal), m_ill[k]);
          else pass_cnt++;
        end
`endif
      end
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_op();
    test_rr_conflict();
    test_fixed_priority();
    test_backpressure();
    test_async_reset();
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
